ctr_table_ctrl: RTL and testbench

- Controller for a 512x2 single-read/single-write SRAM macro holding 2-bit saturating prediction counters.
- Drives the macro's read port (1-cycle read latency, data from registered address) and masked write port.
- On reset, sweeps the whole array to an initial value, then serves lookup requests and read-modify-write counter updates.
- Hazards against the not-yet-committed write are forwarded.

---
 rtl/ctr_table_ctrl_if.sv | 45 ++++
 rtl/ctr_table_ctrl.sv | 94 +++++++++
 tb/tb_ctr_table_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_table_ctrl_if.sv
// Bundle of the lookup, update and SRAM-port signals of the counter table controller.
// The slave modport is the controller's view; the master modport is the client/SRAM side.
interface ctr_table_ctrl_if #(
  parameter int AW = 9
);
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_idx;
  logic          resp_valid;
  logic [1:0]    resp_data;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_idx;
  logic          upd_taken;
  logic          sram_r_en;
  logic [AW-1:0] sram_r_addr;
  logic [1:0]    sram_r_data;
  logic          sram_w_en;
  logic [AW-1:0] sram_w_addr;
  logic [1:0]    sram_w_data;
  logic          sram_w_mask;

  modport slave (
    output init_done,
    input  req_valid, req_idx,
    output req_ready, resp_valid, resp_data,
    input  upd_valid, upd_idx, upd_taken,
    output upd_ready,
    output sram_r_en, sram_r_addr,
    input  sram_r_data,
    output sram_w_en, sram_w_addr, sram_w_data, sram_w_mask
  );

  modport master (
    input  init_done,
    output req_valid, req_idx,
    input  req_ready, resp_valid, resp_data,
    output upd_valid, upd_idx, upd_taken,
    input  upd_ready,
    input  sram_r_en, sram_r_addr,
    output sram_r_data,
    input  sram_w_en, sram_w_addr, sram_w_data, sram_w_mask
  );
endinterface

// File: rtl/ctr_table_ctrl.sv
// Controller for a 512x2 SRAM of 2-bit saturating counters: init sweep, lookups and
// read-modify-write updates with forwarding of the write presented in the read-data cycle.
module ctr_table_ctrl #(
  parameter int         DEPTH    = 512,
  parameter int         AW       = 9,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic             clock,
  input  logic             reset,
  ctr_table_ctrl_if.slave  bus
);
  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic          init_done_q;
  logic          resp_pend_q;
  logic [AW-1:0] rd_idx_q;
  logic          u1_valid_q;
  logic          u1_taken_q;
  logic          u2_valid_q;
  logic [AW-1:0] u2_idx_q;
  logic [1:0]    u2_data_q;

  logic          run;
  logic          lk_acc;
  logic          up_acc;
  logic [AW-1:0] rd_addr;
  logic [1:0]    byp_data;
  logic [1:0]    upd_new;

  assign run     = (state_q == RUN);
  assign lk_acc  = run & bus.req_valid;
  assign up_acc  = run & bus.upd_valid & ~bus.req_valid;
  assign rd_addr = lk_acc ? bus.req_idx : bus.upd_idx;

  // A write presented in the data cycle is not yet in the array, so forward it.
  assign byp_data = (bus.sram_w_en && (bus.sram_w_addr == rd_idx_q)) ? bus.sram_w_data
                                                                     : bus.sram_r_data;

  always_comb begin
    upd_new = byp_data;
    if (u1_taken_q) begin
      if (byp_data != 2'd3) upd_new = byp_data + 2'd1;
    end else begin
      if (byp_data != 2'd0) upd_new = byp_data - 2'd1;
    end
  end

  assign bus.init_done   = init_done_q;
  assign bus.req_ready   = run;
  assign bus.upd_ready   = run & ~bus.req_valid;
  assign bus.resp_valid  = resp_pend_q;
  assign bus.resp_data   = byp_data;
  assign bus.sram_r_en   = lk_acc | up_acc;
  assign bus.sram_r_addr = rd_addr;
  // Sweep writes are gated by reset so nothing is written while reset is held.
  assign bus.sram_w_en   = ~reset & (run ? u2_valid_q : 1'b1);
  assign bus.sram_w_addr = run ? u2_idx_q : ptr_q;
  assign bus.sram_w_data = run ? u2_data_q : INIT_VAL;
  assign bus.sram_w_mask = 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      resp_pend_q <= 1'b0;
      u1_valid_q  <= 1'b0;
      u2_valid_q  <= 1'b0;
    end else begin
      resp_pend_q <= lk_acc;
      u1_valid_q  <= up_acc;
      u1_taken_q  <= bus.upd_taken;
      if (lk_acc | up_acc) rd_idx_q <= rd_addr;
      // Saturated updates leave the counter unchanged and are not written back.
      u2_valid_q  <= u1_valid_q && (upd_new != byp_data);
      u2_idx_q    <= rd_idx_q;
      u2_data_q   <= upd_new;
      case (state_q)
        INIT: begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        RUN: ;
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ctr_table_ctrl.sv
// Self-checking bench for ctr_table_ctrl: directed sweep/saturation/hazard/reset steps plus
// random single-operation traffic compared against a sequential counter-table model.
module tb_ctr_table_ctrl;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk;
  logic reset;

  ctr_table_ctrl_if #(.AW(AW)) bus_if ();

  ctr_table_ctrl #(.DEPTH(DEPTH), .AW(AW), .INIT_VAL(2'b01)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read address, array writes land at the clock edge.
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] raddr_q;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 2'b11;
  always @(posedge clk) begin
    if (bus_if.sram_w_en === 1'b1) mem[bus_if.sram_w_addr] <= bus_if.sram_w_data;
    raddr_q <= bus_if.sram_r_addr;
  end
  assign bus_if.sram_r_data = mem[raddr_q];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cyc = -1;
  int rd_in_init = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  // Write/read monitor sampled well away from the clock edges.
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (bus_if.sram_w_en === 1'b1) begin
      wq_addr.push_back(int'(bus_if.sram_w_addr));
      wq_data.push_back(int'(bus_if.sram_w_data));
      wq_cyc.push_back(cyc);
    end
    if (bus_if.sram_r_en === 1'b1 && bus_if.init_done !== 1'b1) rd_in_init++;
    if (bus_if.init_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  int  ref_ctr[DEPTH];
  bit  pend;
  int  pend_val;
  bit  run_ok;

  function automatic int sat(input int v, input bit tk);
    if (tk) return (v == 3) ? 3 : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cyc   = -1;
    rd_in_init = 0;
  endtask

  task automatic drive(input bit lk, input int li, input bit up, input int ui, input bit tk);
    bus_if.req_valid = lk;
    bus_if.req_idx   = AW'(li);
    bus_if.upd_valid = up;
    bus_if.upd_idx   = AW'(ui);
    bus_if.upd_taken = tk;
  endtask

  // One cycle: drive, check the response owed from the previous cycle, update the model.
  task automatic step(input bit lk, input int li, input bit up, input int ui, input bit tk,
                      output bit la, output bit ua);
    @(negedge clk);
    drive(lk, li, up, ui, tk);
    #1;
    chk("resp_valid", 32'(bus_if.resp_valid), 32'(pend));
    if (pend) chk("resp_data", 32'(bus_if.resp_data), 32'(pend_val));
    if (run_ok) begin
      chk("req_ready", 32'(bus_if.req_ready), 32'd1);
      if (up) chk("upd_ready", 32'(bus_if.upd_ready), 32'(!lk));
    end
    la = lk && (bus_if.req_ready === 1'b1);
    ua = up && (bus_if.upd_ready === 1'b1);
    pend = la;
    if (la) pend_val = ref_ctr[li];
    if (ua) ref_ctr[ui] = sat(ref_ctr[ui], tk);
    $display("cyc %0d lk=%0b/%0d up=%0b/%0d tk=%0b acc=%0b%0b", cyc + 1, lk, li, up, ui, tk, la, ua);
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, a, b);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    pend   = 1'b0;
    run_ok = 1'b0;
    clear_log();
    for (int i = 0; i < DEPTH; i++) ref_ctr[i] = 1;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_init_done", 32'(bus_if.init_done), 32'd0);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_upd_ready", 32'(bus_if.upd_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_r_en", 32'(bus_if.sram_r_en), 32'd0);
    chk("rst_w_en", 32'(bus_if.sram_w_en), 32'd0);
    chk("rst_no_write", 32'(wq_addr.size()), 32'd0);
    clear_log();
    reset = 1'b0;
    $display("reset held %0d cycles, released", n);
  endtask

  task automatic wait_and_check_sweep();
    int bad;
    for (int i = 0; i < 700 && bus_if.init_done !== 1'b1; i++) idle(1);
    chk("init_done_seen", 32'(bus_if.init_done), 32'd1);
    idle(2);
    chk("sweep_count", 32'(wq_addr.size()), 32'd512);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] != i || wq_data[i] != 1) bad++;
    chk("sweep_addr_data", 32'(bad), 32'd0);
    if (wq_cyc.size() == 512) begin
      chk("sweep_consecutive", 32'(wq_cyc[511] - wq_cyc[0]), 32'd511);
      chk("init_done_timing", 32'(done_cyc), 32'(wq_cyc[511] + 1));
    end
    chk("sweep_no_reads", 32'(rd_in_init), 32'd0);
    run_ok = 1'b1;
    clear_log();
  endtask

  initial begin
    bit a, b;
    int t_acc, bad, op, idx;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    pend = 0;
    run_ok = 0;

    // Power-up reset and full sweep.
    apply_reset(2);
    wait_and_check_sweep();

    // Lookups after init.
    step(1, 5, 0, 0, 0, a, b);
    step(1, 511, 0, 0, 0, a, b);
    idle(1);
    chk("lookup_init_val", 32'(ref_ctr[5]), 32'd1);

    // Saturation upward on idx 7.
    clear_log();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 1, a, b);
    idle(3);
    chk("sat_up_writes", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("sat_up_w0", 32'(wq_data[0]), 32'd2);
      chk("sat_up_w1", 32'(wq_data[1]), 32'd3);
      chk("sat_up_addr", 32'(wq_addr[1]), 32'd7);
    end
    step(1, 7, 0, 0, 0, a, b);
    idle(1);

    // Saturation downward on idx 7.
    clear_log();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 7, 0, a, b);
    idle(3);
    chk("sat_dn_writes", 32'(wq_addr.size()), 32'd3);
    if (wq_addr.size() == 3) begin
      chk("sat_dn_w0", 32'(wq_data[0]), 32'd2);
      chk("sat_dn_w1", 32'(wq_data[1]), 32'd1);
      chk("sat_dn_w2", 32'(wq_data[2]), 32'd0);
    end
    step(1, 7, 0, 0, 0, a, b);
    idle(1);

    // Back-to-back updates on idx 9 exercise the forwarding path.
    clear_log();
    step(0, 0, 1, 9, 1, a, b);
    t_acc = cyc + 1;
    step(0, 0, 1, 9, 1, a, b);
    step(0, 0, 1, 9, 1, a, b);
    idle(3);
    chk("b2b_writes", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("b2b_w0_data", 32'(wq_data[0]), 32'd2);
      chk("b2b_w1_data", 32'(wq_data[1]), 32'd3);
      chk("b2b_w0_cycle", 32'(wq_cyc[0]), 32'(t_acc + 2));
      chk("b2b_w1_cycle", 32'(wq_cyc[1]), 32'(t_acc + 3));
    end
    step(1, 9, 0, 0, 0, a, b);
    idle(1);

    // Arbitration: lookup wins, update follows next cycle.
    step(1, 20, 1, 30, 1, a, b);
    chk("arb_lookup_acc", 32'(a), 32'd1);
    chk("arb_update_held", 32'(b), 32'd0);
    step(0, 0, 1, 30, 1, a, b);
    chk("arb_update_acc", 32'(b), 32'd1);
    idle(3);
    step(1, 30, 0, 0, 0, a, b);
    idle(1);
    chk("arb_model_30", 32'(ref_ctr[30]), 32'd2);

    // Random single-operation traffic on a small index window.
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(2);
      idx = $urandom_range(15);
      if (op == 1) step(1, idx, 0, 0, 0, a, b);
      else if (op == 2) step(0, 0, 1, idx, $urandom_range(1), a, b);
      else idle(1);
    end
    idle(4);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != ref_ctr[i]) bad++;
    chk("array_vs_model", 32'(bad), 32'd0);

    // Reset mid-sweep at pointer 200.
    apply_reset(1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (bus_if.sram_w_addr === AW'(199)) break;
    end
    chk("sweep_reached_199", 32'(bus_if.sram_w_addr), 32'd199);
    apply_reset(2);
    wait_and_check_sweep();

    // Reset while an update sits in U1: its write must never appear.
    idle(2);
    step(0, 0, 1, 40, 1, a, b);
    chk("u1_update_acc", 32'(b), 32'd1);
    apply_reset(3);
    wait_and_check_sweep();
    step(1, 40, 0, 0, 0, a, b);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
